// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default address/instruction widths
// and the enable/zero levels used when qualifying control and clearing outputs.
package fetch_queue_pkg;

  localparam int FQ_AW_DEFAULT = 32;
  localparam int FQ_IW_DEFAULT = 32;

  localparam logic FQ_ON  = 1'b1;
  localparam logic FQ_OFF = 1'b0;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between IF and ID.
// Stores {pc, inst, jump} and presents the head entry to ID one cycle after enqueue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = FQ_AW_DEFAULT,
  parameter int IW    = FQ_IW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [AW-1:0]          if_pc,
  input  logic [IW-1:0]          if_inst,
  input  logic                   if_jump,
  output logic                   if_ready,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [AW-1:0]          id_pc,
  output logic [IW-1:0]          id_inst,
  output logic                   id_jump,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] pc_q   [DEPTH];
  logic [AW-1:0] pc_d   [DEPTH];
  logic [IW-1:0] inst_q [DEPTH];
  logic [IW-1:0] inst_d [DEPTH];
  logic          jump_q [DEPTH];
  logic          jump_d [DEPTH];

  logic run;
  logic enq;
  logic deq;

  // No full-queue bypass: if_ready depends only on the registered count.
  assign if_ready = (count_q < FULL_CNT);
  assign id_valid = (count_q != '0);
  assign id_pc    = id_valid ? pc_q[rptr_q]   : '0;
  assign id_inst  = id_valid ? inst_q[rptr_q] : '0;
  assign id_jump  = id_valid ? jump_q[rptr_q] : FQ_OFF;
  assign count    = count_q;

  assign run = (rdy == FQ_ON) && (flush == FQ_OFF);
  assign enq = run && if_valid && if_ready;
  assign deq = run && id_ready && id_valid;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if ((rdy == FQ_ON) && (flush == FQ_ON)) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PW'(1);
      if (deq) rptr_d = rptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    jump_d = jump_q;
    if (enq) begin
      pc_d[wptr_q]   = if_pc;
      inst_d[wptr_q] = if_inst;
      jump_d[wptr_q] = if_jump;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left out of reset; count gates visibility.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
    jump_q <= jump_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, 32-bit pc/inst).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_valid, if_jump, if_ready;
  logic [31:0] if_pc, if_inst;
  logic        id_ready, id_valid, id_jump;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .AW(32), .IW(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_jump(if_jump),
    .if_ready(if_ready), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .id_jump(id_jump), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic j,
                       input logic idr, input logic fl, input logic r);
    if_valid = v;
    if_pc    = pc;
    if_inst  = 32'h1000_0000 | pc;
    if_jump  = j;
    id_ready = idr;
    flush    = fl;
    rdy      = r;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();

    // reset with a same-cycle enqueue attempt
    drive(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    idle();
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd1);
    check("rst_id_pc",    id_pc,         32'h0);
    check("rst_id_inst",  id_inst,       32'h0);
    check("rst_id_jump",  32'(id_jump),  32'd0);
    step();
    check("rst_not_stored", 32'(count), 32'd0);

    // fill
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_head",  id_pc,      32'h0);
    end
    check("full_if_ready", 32'(if_ready), 32'd0);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("fifth_refused", 32'(count), 32'd4);

    // drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("drain_pc",   id_pc,   32'(i * 4));
      check("drain_inst", id_inst, 32'h1000_0000 | 32'(i * 4));
      step();
    end
    idle();
    check("drained_valid", 32'(id_valid), 32'd0);
    check("drained_count", 32'(count),    32'd0);
    check("drained_pc",    id_pc,         32'h0);

    // wrap: two in flight, four overlapped enq+deq, then drain two
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1); step();
    check("wrap_prime_count", 32'(count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h108 + 32'(i * 4), 1'b0, 1'b1, 1'b0, 1'b1);
      check("wrap_head", id_pc, 32'h100 + 32'(i * 4));
      step();
      check("wrap_count", 32'(count), 32'd2);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("wrap_tail", id_pc, 32'h110 + 32'(i * 4));
      step();
    end
    idle();
    check("wrap_empty", 32'(count), 32'd0);

    // simultaneous enq+deq at count=2, jump tag carried
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1); step();
    check("sim_count", 32'(count), 32'd2);
    check("sim_head",  id_pc,      32'h4);
    check("sim_jump0", 32'(id_jump), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1); step();
    check("sim_head2", id_pc,        32'h8);
    check("sim_jump1", 32'(id_jump), 32'd1);
    step();
    idle();
    check("sim_empty", 32'(count), 32'd0);

    // flush with three entries and a same-cycle enqueue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    drive(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    check("flush_count", 32'(count),    32'd0);
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_pc",    id_pc,         32'h0);
    step();
    check("flush_0x20_absent", 32'(count), 32'd0);

    // rdy low freezes everything
    drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h64, 1'b0, 1'b0, 1'b0, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h68, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      check("rdy_lo_count", 32'(count), 32'd2);
      check("rdy_lo_head",  id_pc,      32'h60);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("rdy_lo_flush_held", 32'(count), 32'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1); step();
    check("rdy_hi_head", id_pc, 32'h64);
    step();
    idle();
    check("rdy_hi_empty", 32'(count), 32'd0);

    // full + dequeue same cycle: no bypass
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h80 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b1, 32'h90, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check("nobypass_count", 32'(count), 32'd3);
    check("nobypass_head",  id_pc,      32'h84);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); step();
    check("nobypass_last", id_pc, 32'h8C);
    step();
    idle();
    check("nobypass_empty", 32'(count), 32'd0);

    // reset mid-operation beats rdy low and flush
    drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("midrst_count",    32'(count),    32'd0);
    check("midrst_valid",    32'(id_valid), 32'd0);
    check("midrst_if_ready", 32'(if_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
